// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: host-side SPI master that turns valid/ready requests into
// slave frames of {cmd[1:0], payload} sent MSB first. A CHK_CMD lead bit comes
// first, then the frame. Read-data commands (11) add a turnaround and an
// ADDR_SIZE-bit capture from miso. Every frame is followed by an ss_n-high gap.
// Optional build macro: SPI_MASTER_SEQ_CHECK_EN (adds the err port and blocks
// a read-data command that has no earlier read-address command).
module spi_master_ctrl #(
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned TURN_CYC  = 2,
   parameter int unsigned GAP_CYC   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_cmd,
   input  logic [ADDR_SIZE-1:0] req_data,
   output logic                 rsp_valid,
   output logic [ADDR_SIZE-1:0] rsp_data,
   output logic                 busy,
   output logic                 ss_n,
   output logic                 mosi,
   input  logic                 miso
`ifdef SPI_MASTER_SEQ_CHECK_EN
   ,
   output logic                 err
`endif
);

   localparam int unsigned FW = ADDR_SIZE + 2;
   localparam int unsigned CW = $clog2(FW + TURN_CYC + GAP_CYC + 2);

   localparam logic [CW-1:0] C_FW    = CW'(FW);
   localparam logic [CW-1:0] C_TURN  = CW'(TURN_CYC);
   localparam logic [CW-1:0] C_GAP   = CW'(GAP_CYC);
   localparam logic [CW-1:0] C_RLAST = CW'(ADDR_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_SHIFT, S_TURN, S_RECV, S_GAP, S_ERR
   } state_t;

   state_t               r_state, w_state;
   logic [CW-1:0]        r_cnt, w_cnt;
   logic [FW-1:0]        r_shift, w_shift;
   logic [1:0]           r_cmd, w_cmd;
   logic [ADDR_SIZE-2:0] r_rx, w_rx;
   logic                 r_ss_n, w_ss_n;
   logic                 r_mosi, w_mosi;
   logic                 r_req_ready, w_req_ready;
   logic                 r_rsp_valid, w_rsp_valid;
   logic [ADDR_SIZE-1:0] r_rsp_data, w_rsp_data;
   logic                 r_busy, w_busy;
   logic                 w_accept;
`ifdef SPI_MASTER_SEQ_CHECK_EN
   logic                 r_seen, w_seen;
   logic                 r_err, w_err;
`endif

   assign w_accept = req_valid & r_req_ready;

   // State and registered-output update; async reset forces the bus idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_cmd       <= '0;
         r_rx        <= '0;
         r_ss_n      <= 1'b1;
         r_mosi      <= 1'b1;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_busy      <= 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
         r_seen      <= 1'b0;
         r_err       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_shift     <= w_shift;
         r_cmd       <= w_cmd;
         r_rx        <= w_rx;
         r_ss_n      <= w_ss_n;
         r_mosi      <= w_mosi;
         r_req_ready <= w_req_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_data  <= w_rsp_data;
         r_busy      <= w_busy;
`ifdef SPI_MASTER_SEQ_CHECK_EN
         r_seen      <= w_seen;
         r_err       <= w_err;
`endif
      end
   end

   // Next state plus the next value of every registered output.
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_shift     = r_shift;
      w_cmd       = r_cmd;
      w_rx        = r_rx;
      w_ss_n      = r_ss_n;
      w_mosi      = r_mosi;
      w_req_ready = r_req_ready;
      w_rsp_valid = 1'b0;
      w_rsp_data  = r_rsp_data;
      w_busy      = r_busy;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      w_seen      = r_seen;
      w_err       = 1'b0;
`endif
      unique case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            w_ss_n      = 1'b1;
            w_mosi      = 1'b1;
            w_busy      = 1'b0;
            if (w_accept) begin
               w_req_ready = 1'b0;
               w_cmd       = req_cmd;
               w_shift     = {req_cmd, req_data};
               w_cnt       = '0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
               if (req_cmd == 2'b11 && !r_seen) begin
                  w_state = S_ERR;
                  w_err   = 1'b1;
               end else begin
                  if (req_cmd == 2'b10) w_seen = 1'b1;
                  w_state = S_START;
                  w_ss_n  = 1'b0;
                  w_mosi  = req_cmd[1];
                  w_busy  = 1'b1;
               end
`else
               w_state = S_START;
               w_ss_n  = 1'b0;
               w_mosi  = req_cmd[1];
               w_busy  = 1'b1;
`endif
            end
         end
         S_START: begin
            w_mosi  = r_shift[FW-1];
            w_shift = {r_shift[FW-2:0], 1'b0};
            w_cnt   = CW'(1);
            w_state = S_SHIFT;
         end
         S_SHIFT: begin
            if (r_cnt == C_FW) begin
               w_mosi = 1'b1;
               if (r_cmd == 2'b11) begin
                  if (TURN_CYC == 0) begin
                     w_state = S_RECV;
                     w_cnt   = '0;
                  end else begin
                     w_state = S_TURN;
                     w_cnt   = CW'(1);
                  end
               end else begin
                  w_state = S_GAP;
                  w_ss_n  = 1'b1;
                  w_busy  = 1'b0;
                  w_cnt   = CW'(1);
               end
            end else begin
               w_mosi  = r_shift[FW-1];
               w_shift = {r_shift[FW-2:0], 1'b0};
               w_cnt   = r_cnt + CW'(1);
            end
         end
         S_TURN: begin
            if (r_cnt == C_TURN) begin
               w_state = S_RECV;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_RECV: begin
            // Last sample bypasses the capture register so rsp_data and
            // rsp_valid appear on the same edge.
            if (r_cnt == C_RLAST) begin
               w_rsp_data  = {r_rx, miso};
               w_rsp_valid = 1'b1;
               w_state     = S_GAP;
               w_ss_n      = 1'b1;
               w_busy      = 1'b0;
               w_cnt       = CW'(1);
`ifdef SPI_MASTER_SEQ_CHECK_EN
               w_seen      = 1'b0;
`endif
            end else begin
               w_rx  = {r_rx[ADDR_SIZE-3:0], miso};
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_GAP: begin
            if (r_cnt == C_GAP) begin
               w_state     = S_IDLE;
               w_req_ready = 1'b1;
               w_cnt       = '0;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_ERR: begin
            w_state     = S_IDLE;
            w_req_ready = 1'b1;
         end
         default: begin
            w_state = S_IDLE;
            w_ss_n  = 1'b1;
            w_mosi  = 1'b1;
            w_busy  = 1'b0;
            w_cnt   = '0;
         end
      endcase
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign busy      = r_busy;
   assign ss_n      = r_ss_n;
   assign mosi      = r_mosi;
`ifdef SPI_MASTER_SEQ_CHECK_EN
   assign err       = r_err;
`endif

endmodule
